// File: rtl/spell_mem_arbiter_pkg.sv
// Shared encodings and arbitration rule for spell_mem_arbiter.
// Optional macro SPELL_MEM_ARB_ROUND_ROBIN_EN selects alternating priority on contention.
package spell_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_TYPE_NONE = 2'd0;
  localparam logic [1:0] MEM_TYPE_CODE = 2'd1;
  localparam logic [1:0] MEM_TYPE_DATA = 2'd2;

  typedef struct packed {
    logic   grant;
    owner_e who;
  } arb_pick_t;

  function automatic arb_pick_t pick_winner(input logic   core_sel,
                                            input logic   host_sel,
                                            input logic   host_lock,
                                            input owner_e last);
    arb_pick_t pick;
    logic      core_blocked;
    core_blocked = host_lock && (last == OWNER_HOST);
    pick.grant   = 1'b0;
    pick.who     = last;
    if (core_sel && host_sel && !core_blocked) begin
      pick.grant = 1'b1;
`ifdef SPELL_MEM_ARB_ROUND_ROBIN_EN
      pick.who   = (last == OWNER_HOST) ? OWNER_CORE : OWNER_HOST;
`else
      pick.who   = OWNER_HOST;
`endif
    end else if (host_sel) begin
      pick.grant = 1'b1;
      pick.who   = OWNER_HOST;
    end else if (core_sel && !core_blocked) begin
      pick.grant = 1'b1;
      pick.who   = OWNER_CORE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/spell_mem_arbiter.sv
// Two-requester arbiter (spell core / Wishbone host) for the single spell memory port.
// Build option: SPELL_MEM_ARB_ROUND_ROBIN_EN (see spell_mem_arbiter_pkg::pick_winner).
module spell_mem_arbiter
  import spell_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TYPE_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_select,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic [TYPE_WIDTH-1:0] core_type,
  input  logic                  core_write,
  output logic [DATA_WIDTH-1:0] core_data_out,
  output logic                  core_ready,
  input  logic                  host_select,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data_in,
  input  logic [TYPE_WIDTH-1:0] host_type,
  input  logic                  host_write,
  input  logic                  host_lock,
  output logic [DATA_WIDTH-1:0] host_data_out,
  output logic                  host_ready,
  output logic                  mem_select,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [TYPE_WIDTH-1:0] mem_type,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  output logic                  busy,
  output logic                  owner
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  mem_select_q, mem_select_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic [TYPE_WIDTH-1:0] mem_type_q, mem_type_d;
  logic                  mem_write_q, mem_write_d;
  logic                  core_ready_q, core_ready_d;
  logic                  host_ready_q, host_ready_d;
  logic [DATA_WIDTH-1:0] core_data_out_q, core_data_out_d;
  logic [DATA_WIDTH-1:0] host_data_out_q, host_data_out_d;
  arb_pick_t             pick;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    mem_select_d    = mem_select_q;
    mem_addr_d      = mem_addr_q;
    mem_data_in_d   = mem_data_in_q;
    mem_type_d      = mem_type_q;
    mem_write_d     = mem_write_q;
    core_ready_d    = 1'b0;
    host_ready_d    = 1'b0;
    core_data_out_d = core_data_out_q;
    host_data_out_d = host_data_out_q;
    pick            = pick_winner(core_select, host_select, host_lock, owner_q);

    case (state_q)
      ARB_IDLE: begin
        if (pick.grant) begin
          owner_d      = pick.who;
          mem_select_d = 1'b1;
          state_d      = ARB_ACCESS;
          if (pick.who == OWNER_HOST) begin
            mem_addr_d    = host_addr;
            mem_data_in_d = host_data_in;
            mem_type_d    = host_type;
            mem_write_d   = host_write;
          end else begin
            mem_addr_d    = core_addr;
            mem_data_in_d = core_data_in;
            mem_type_d    = core_type;
            mem_write_d   = core_write;
          end
        end
      end
      ARB_ACCESS: begin
        // Request inputs are ignored here; only the latched copy reaches memory.
        if (mem_select_q && mem_data_ready) begin
          mem_select_d = 1'b0;
          state_d      = ARB_RELEASE;
          if (owner_q == OWNER_HOST) begin
            host_data_out_d = mem_data_out;
            host_ready_d    = 1'b1;
          end else begin
            core_data_out_d = mem_data_out;
            core_ready_d    = 1'b1;
          end
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default: begin
        state_d      = ARB_IDLE;
        mem_select_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWNER_CORE;
      mem_select_q    <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_in_q   <= '0;
      mem_type_q      <= '0;
      mem_write_q     <= 1'b0;
      core_ready_q    <= 1'b0;
      host_ready_q    <= 1'b0;
      core_data_out_q <= '0;
      host_data_out_q <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      mem_select_q    <= mem_select_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_in_q   <= mem_data_in_d;
      mem_type_q      <= mem_type_d;
      mem_write_q     <= mem_write_d;
      core_ready_q    <= core_ready_d;
      host_ready_q    <= host_ready_d;
      core_data_out_q <= core_data_out_d;
      host_data_out_q <= host_data_out_d;
    end
  end

  assign mem_select    = mem_select_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data_in   = mem_data_in_q;
  assign mem_type      = mem_type_q;
  assign mem_write     = mem_write_q;
  assign core_ready    = core_ready_q;
  assign host_ready    = host_ready_q;
  assign core_data_out = core_data_out_q;
  assign host_data_out = host_data_out_q;
  assign busy          = (state_q != ARB_IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Bench for spell_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (memory array, per-requester scoreboard, grant rules).
module tb_spell_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TW = 2;
  localparam logic [1:0] T_CODE = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
`ifdef SPELL_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          core_select = 1'b0, core_write = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_data_in = '0;
  logic [TW-1:0] core_type = '0;
  logic          host_select = 1'b0, host_write = 1'b0, host_lock = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data_in = '0;
  logic [TW-1:0] host_type = '0;
  logic [DW-1:0] core_data_out, host_data_out, mem_data_in;
  logic          core_ready, host_ready, mem_select, mem_write, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] mem_type;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_data_ready = 1'b0;

  spell_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TYPE_WIDTH(TW)) dut (
    .clock(clock), .reset(reset),
    .core_select(core_select), .core_addr(core_addr), .core_data_in(core_data_in),
    .core_type(core_type), .core_write(core_write),
    .core_data_out(core_data_out), .core_ready(core_ready),
    .host_select(host_select), .host_addr(host_addr), .host_data_in(host_data_in),
    .host_type(host_type), .host_write(host_write), .host_lock(host_lock),
    .host_data_out(host_data_out), .host_ready(host_ready),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_type(mem_type), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers a selected access after a wait, writes return written data.
  logic [DW-1:0] mem [4][256];
  int fixed_lat = -1;
  int lat = -1;

  always @(negedge clock) begin
    if (mem_data_ready) begin
      mem_data_ready = 1'b0;
    end else if (!mem_select) begin
      lat = -1;
    end else begin
      if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      if (lat == 0) begin
        if (mem_write) begin
          mem[mem_type][mem_addr] = mem_data_in;
          mem_data_out = mem_data_in;
        end else begin
          mem_data_out = mem[mem_type][mem_addr];
        end
        mem_data_ready = 1'b1;
        lat = -1;
      end else begin
        lat--;
      end
    end
  end

  // Grant rule: -1 none, 0 core, 1 host.
  function automatic int exp_winner(bit c, bit h, bit lk, int last);
    bit blocked;
    blocked = lk && (last == 1);
    if (c && h && !blocked) return RR_EN ? (1 - last) : 1;
    if (h) return 1;
    if (c && !blocked) return 0;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_grant(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clock);
      if (mem_select) ok = 1'b1;
    end
  endtask

  task automatic wait_ready(input int who, input int max, output bit ok, output bit other);
    ok = 1'b0;
    other = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clock);
      if ((who == 1) ? core_ready : host_ready) other = 1'b1;
      if ((who == 1) ? host_ready : core_ready) ok = 1'b1;
    end
  endtask

  // Randomized traffic state, index 0 = core, 1 = host.
  bit            pend[2], granted[2], sel[2], snap_sel[2];
  int            gap[2], age[2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_data[2], exp_out[2];
  logic [TW-1:0] r_type[2];
  bit            r_wr[2];
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [TW-1:0] cur_type;
  bit            cur_wr, lock_r, snap_idle, snap_lock, issue_en;
  int            last_owner;

  task automatic rand_step();
    int w;
    for (int r = 0; r < 2; r++) begin
      if ((r == 1) ? host_ready : core_ready) begin
        chk("rnd_ready_owner", 1, pend[r] && granted[r]);
        chk("rnd_data_out", (r == 1) ? host_data_out : core_data_out, exp_out[r]);
        pend[r] = 0; granted[r] = 0; sel[r] = 0;
        gap[r] = $urandom_range(1, 4);
      end
    end
    if (snap_idle) begin
      w = exp_winner(snap_sel[0], snap_sel[1], snap_lock, last_owner);
      chk("rnd_grant_valid", mem_select, w >= 0);
      if (w >= 0 && mem_select) begin
        chk("rnd_grant_who", owner, w);
        chk("rnd_grant_req", {mem_addr, mem_data_in, mem_type, mem_write},
            {r_addr[w], r_data[w], r_type[w], r_wr[w]});
        cur_addr = r_addr[w]; cur_data = r_data[w]; cur_type = r_type[w]; cur_wr = r_wr[w];
        exp_out[w] = r_wr[w] ? r_data[w] : mem[r_type[w]][r_addr[w]];
        granted[w] = 1; last_owner = w;
      end
    end else if (mem_select) begin
      chk("rnd_hold", {mem_addr, mem_data_in, mem_type, mem_write},
          {cur_addr, cur_data, cur_type, cur_wr});
    end
    for (int r = 0; r < 2; r++) begin
      if (!pend[r]) begin
        if (gap[r] > 0) gap[r]--;
        else if (issue_en && ($urandom_range(0, 2) == 0)) begin
          pend[r] = 1; sel[r] = 1; age[r] = 0;
          r_addr[r] = $urandom; r_data[r] = $urandom;
          r_type[r] = $urandom; r_wr[r] = $urandom;
        end
      end else begin
        age[r]++;
        if (granted[r]) begin
          r_addr[r] = $urandom; r_data[r] = $urandom;
          r_type[r] = $urandom; r_wr[r] = $urandom;
          if ($urandom_range(0, 7) == 0) sel[r] = 0;
        end
        if (age[r] > 400) begin
          chk("rnd_timeout", age[r], 0);
          pend[r] = 0; sel[r] = 0; granted[r] = 0;
        end
      end
    end
    if (!issue_en) lock_r = 0;
    else if ($urandom_range(0, 15) == 0) lock_r = ~lock_r;
    core_select = sel[0]; core_addr = r_addr[0]; core_data_in = r_data[0];
    core_type = r_type[0]; core_write = r_wr[0];
    host_select = sel[1]; host_addr = r_addr[1]; host_data_in = r_data[1];
    host_type = r_type[1]; host_write = r_wr[1];
    host_lock = lock_r;
    snap_idle = !busy; snap_sel[0] = sel[0]; snap_sel[1] = sel[1]; snap_lock = lock_r;
  endtask

  bit ok, other, saw;
  int rr_exp[4];

  initial begin
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < 256; a++) mem[t][a] = $urandom;
    mem[T_CODE][8'h10] = 8'h3F;

    // Reset state
    tick(); tick();
    chk("rst_outputs", {mem_select, busy, owner, core_ready, host_ready, mem_write}, 0);
    chk("rst_data", {core_data_out, host_data_out, mem_addr}, 0);
    reset = 1'b0;
    tick();

    // Core read of code 0x10
    fixed_lat = 3;
    core_select = 1; core_addr = 8'h10; core_type = T_CODE; core_write = 0; core_data_in = 0;
    tick();
    chk("cr_grant", {mem_select, busy}, 2'b11);
    chk("cr_addr", {mem_addr, mem_type, mem_write}, {8'h10, T_CODE, 1'b0});
    wait_ready(0, 20, ok, other);
    chk("cr_ready", ok, 1);
    chk("cr_data", core_data_out, 8'h3F);
    chk("cr_mem_dropped", mem_select, 0);
    core_select = 0;
    tick();
    chk("cr_pulse_once", core_ready, 0);
    chk("cr_host_quiet", {other, host_ready}, 0);

    // Simultaneous: host read 0x05 beats core write 0x20 <- 0xAA
    fixed_lat = 1;
    core_select = 1; core_addr = 8'h20; core_data_in = 8'hAA; core_type = T_DATA; core_write = 1;
    host_select = 1; host_addr = 8'h05; host_type = T_DATA; host_write = 0; host_data_in = 8'h11;
    tick();
    chk("sim_first", {mem_select, owner, mem_addr, mem_write}, {1'b1, 1'b1, 8'h05, 1'b0});
    wait_ready(1, 20, ok, other);
    chk("sim_host_ready", {ok, other}, 2'b10);
    chk("sim_host_data", host_data_out, mem[T_DATA][8'h05]);
    host_select = 0;
    wait_grant(4, ok);
    chk("sim_second", {ok, owner, mem_addr, mem_data_in, mem_write},
        {1'b1, 1'b0, 8'h20, 8'hAA, 1'b1});
    wait_ready(0, 20, ok, other);
    chk("sim_core_ready", {ok, other}, 2'b10);
    chk("sim_core_data", core_data_out, 8'hAA);
    core_select = 0;
    tick();

    // Lock: host keeps the port across three reads while the core waits
    fixed_lat = 0;
    host_lock = 1;
    core_select = 1; core_addr = 8'h30; core_type = T_CODE; core_write = 0;
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      host_select = 1; host_addr = 8'(i); host_type = T_CODE; host_write = 0;
      wait_grant(4, ok);
      chk("lk_grant", {ok, owner, mem_addr}, {1'b1, 1'b1, 8'(i)});
      wait_ready(1, 20, ok, other);
      chk("lk_host_data", {ok, host_data_out}, {1'b1, mem[T_CODE][8'(i)]});
      saw = saw | other;
      host_select = 0;
      tick(); tick();
      chk("lk_core_blocked", {mem_select, core_ready}, 0);
    end
    chk("lk_no_core_ready", saw, 0);
    host_lock = 0;
    wait_grant(2, ok);
    chk("lk_core_grant", {ok, owner, mem_addr}, {1'b1, 1'b0, 8'h30});
    wait_ready(0, 20, ok, other);
    chk("lk_core_data", {ok, core_data_out}, {1'b1, mem[T_CODE][8'h30]});
    core_select = 0;
    tick();

    // Contention: both re-request immediately after each completion
    if (RR_EN) begin rr_exp[0] = 1; rr_exp[1] = 0; rr_exp[2] = 1; rr_exp[3] = 0; end
    else       begin rr_exp[0] = 1; rr_exp[1] = 1; rr_exp[2] = 1; rr_exp[3] = 1; end
    core_select = 1; core_addr = 8'h40; core_type = T_DATA; core_write = 0;
    host_select = 1; host_addr = 8'h41; host_type = T_DATA; host_write = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(4, ok);
      chk("cont_grant", {ok, owner}, {1'b1, 1'(rr_exp[i])});
      wait_ready(rr_exp[i], 20, ok, other);
      chk("cont_ready", ok, 1);
      if (rr_exp[i] == 1) host_select = 0; else core_select = 0;
      tick();
      if (i < 3) begin
        if (rr_exp[i] == 1) host_select = 1; else core_select = 1;
      end
    end
    host_select = 0;
    if (core_select) begin
      wait_grant(4, ok);
      wait_ready(0, 20, ok, other);
      chk("cont_core_drain", ok, 1);
      core_select = 0;
    end
    tick(); tick();

    // Reset in the middle of an access
    fixed_lat = 20;
    host_select = 1; host_addr = 8'h07; host_write = 0;
    tick();
    chk("mr_grant", mem_select, 1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("mr_async_clear", {mem_select, busy, core_ready, host_ready, owner}, 0);
    host_select = 0;
    tick();
    reset = 1'b0;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw = saw | core_ready | host_ready | busy | mem_select;
    end
    chk("mr_quiet_after", saw, 0);

    // Randomized traffic against the model
    fixed_lat = -1;
    last_owner = 0; lock_r = 0; snap_idle = 0; issue_en = 1;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 0; granted[r] = 0; sel[r] = 0; gap[r] = 0; age[r] = 0;
      r_addr[r] = 0; r_data[r] = 0; r_type[r] = 0; r_wr[r] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      rand_step();
    end
    issue_en = 0;
    for (int c = 0; c < 600 && (pend[0] || pend[1]); c++) begin
      tick();
      rand_step();
    end
    chk("rnd_drained", pend[0] | pend[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
